// File: rtl/gpu_pkg.sv
// Shared defaults for the GPU memory server: bus widths, core count and core opcode constants.
package gpu_pkg;

  localparam int unsigned GPU_DATA_W    = 16;
  localparam int unsigned GPU_ADDR_W    = 16;
  localparam int unsigned GPU_NUM_CORES = 4;

  typedef enum logic [3:0] {
    OP_MOV  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_BR   = 4'd8,
    OP_SPWN = 4'd9
  } core_op_e;

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// Grant selector for gpu_mem_server: round-robin when GPU_MEM_RR_EN is defined,
// fixed lowest-index priority otherwise (no pointer state, no clock needed).
module gpu_rr_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned N  = GPU_NUM_CORES,
  parameter int unsigned IW = idx_w(N)
) (
`ifdef GPU_MEM_RR_EN
  input  logic          clk,
  input  logic          rst,
`endif
  input  logic [N-1:0]  eligible,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

`ifdef GPU_MEM_RR_EN
  logic [IW-1:0] ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!any_grant && eligible[(32'(ptr) + off) % N]) begin
        grant[(32'(ptr) + off) % N] = 1'b1;
        grant_idx = IW'((32'(ptr) + off) % N);
        any_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_grant && eligible[i]) begin
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
        any_grant = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/gpu_mem_server.sv
// Single-ported program/data RAM serving per-core read requests with 1-cycle latency
// plus a priority loader write port. Arbitration mode selected by GPU_MEM_RR_EN.
module gpu_mem_server
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CORES = GPU_NUM_CORES,
  parameter int unsigned ADDR_W    = GPU_ADDR_W,
  parameter int unsigned DATA_W    = GPU_DATA_W,
  parameter int unsigned DEPTH     = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        ld_we,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        busy
);

  localparam int unsigned IW     = idx_w(NUM_CORES);
  localparam int unsigned MEM_AW = idx_w(DEPTH);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] grant;
  logic [IW-1:0]        grant_idx;
  logic                 any_grant;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_in_range;
  logic                 ld_in_range;

  // rsp_valid is the in-flight register: the core being answered cannot be re-granted
  // off its still-held request, and a loader write blocks all grants that cycle.
  assign eligible    = ld_we ? '0 : (req_valid & ~rsp_valid);
  assign rd_addr     = req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
  assign rd_in_range = (32'(rd_addr) < DEPTH);
  assign ld_in_range = (32'(ld_addr) < DEPTH);
  assign busy        = (|req_valid) | (|rsp_valid);

  gpu_rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_arb (
`ifdef GPU_MEM_RR_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk) begin
    if (ld_we && ld_in_range) begin
      mem[ld_addr[MEM_AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= grant;
      if (any_grant) begin
        rsp_data <= rd_in_range ? mem[rd_addr[MEM_AW-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_mem_server.sv
// Scoreboard bench for gpu_mem_server: directed scenarios plus random traffic, checked
// against a queue/array reference model. Honours GPU_MEM_RR_EN for the arbitration rule.
module tb_gpu_mem_server;

  localparam int NC    = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC-1:0]  req_valid;
  logic [NC*AW-1:0] req_addr;
  logic [NC-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           ld_we;
  logic [AW-1:0]  ld_addr;
  logic [DW-1:0]  ld_data;
  logic           busy;

  logic [NC-1:0]  rv;
  logic [AW-1:0]  ra [NC];

  assign req_valid = rv;
  assign req_addr  = {ra[3], ra[2], ra[1], ra[0]};

  gpu_mem_server #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          core;
    logic [15:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] ref_mem [DEPTH];
  int          ptr    = 0;
  int          last_g = -1;
  int          cycle  = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int pick(logic [3:0] e);
`ifdef GPU_MEM_RR_EN
    for (int k = 0; k < NC; k++)
      if (e[(ptr + k) % NC]) return (ptr + k) % NC;
`else
    for (int k = 0; k < NC; k++)
      if (e[k]) return k;
`endif
    return -1;
  endfunction

  // Predict the coming edge from the current drive values, then advance one cycle.
  task automatic tick();
    logic [3:0] e;
    int         g;
    int         og;
    exp_t       x;
    e = rv;
    if (last_g >= 0) e[last_g] = 1'b0;
    if (ld_we) e = '0;
    g = pick(e);
    if (ld_we && int'(ld_addr) < DEPTH) ref_mem[ld_addr[11:0]] = ld_data;
    if (g >= 0) begin
      x.cyc  = cycle + 1;
      x.core = g;
      x.data = (int'(ra[g]) < DEPTH) ? ref_mem[ra[g][11:0]] : 16'h0000;
      sbq.push_back(x);
      ptr = (g + 1) % NC;
    end
    og     = last_g;
    last_g = g;
    @(posedge clk);
    #1;
    if (og >= 0) rv[og] = 1'b0;
  endtask

  task automatic drain(input int n);
    ld_we = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [3:0]  m_ev;
  logic [15:0] m_ed;
  bit          m_exp;

  always @(negedge clk) begin
    m_exp = (sbq.size() > 0) && (sbq[0].cyc == cycle);
    checks++;
    if (m_exp) begin
      m_ev = 4'(1 << sbq[0].core);
      m_ed = sbq[0].data;
      void'(sbq.pop_front());
      if (rsp_valid !== m_ev || rsp_data !== m_ed) begin
        errors++;
        $display("FAIL rsp cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                 cycle, rsp_valid, rsp_data, m_ev, m_ed);
      end
    end else if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL idle_rsp cyc=%0d: got valid=%b, want 0000", cycle, rsp_valid);
    end
    checks++;
    if (busy !== ((|rv) || m_exp)) begin
      errors++;
      $display("FAIL busy cyc=%0d: got %b, want %b", cycle, busy, ((|rv) || m_exp));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] init_vals [4];
    init_vals[0] = 16'h1234;
    init_vals[1] = 16'h3005;
    init_vals[2] = 16'h2000;
    init_vals[3] = 16'hABCD;

    rst = 1'b1; rv = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < NC; i++) ra[i] = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h busy=%b, want 0000/0000/0",
               rsp_valid, rsp_data, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload words 0..63; the first four are the fixed program words.
    for (int a = 0; a < 64; a++) begin
      ld_we = 1'b1; ld_addr = 16'(a);
      ld_data = (a < 4) ? init_vals[a] : 16'($urandom);
      tick();
    end
    ld_we = 1'b0;

    rv[0] = 1'b1; ra[0] = 16'd1;
    drain(3);

    for (int i = 0; i < NC; i++) begin rv[i] = 1'b1; ra[i] = 16'(i); end
    drain(8);

    ld_we = 1'b1; ld_addr = 16'd5; ld_data = 16'hBEEF;
    rv[2] = 1'b1; ra[2] = 16'd5;
    tick();
    drain(3);

    rv[1] = 1'b1; ra[1] = 16'hF000;
    drain(3);

    // Cores 0 and 2 hammer continuously; core 3 joins midway.
    for (int k = 0; k < 10; k++) begin
      if (!rv[0]) begin rv[0] = 1'b1; ra[0] = 16'd10; end
      if (!rv[2]) begin rv[2] = 1'b1; ra[2] = 16'd11; end
      if (k == 3) begin rv[3] = 1'b1; ra[3] = 16'd12; end
      tick();
    end
    drain(8);

    // Reset while a core-3 response is in flight.
    rv[3] = 1'b1; ra[3] = 16'd3;
    tick();
    rst = 1'b1;
    sbq.delete(); last_g = -1; ptr = 0;
    @(posedge clk); #1;
    checks++;
    if (rsp_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_data: got %h, want 0000", rsp_data);
    end
    rv = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rv[3] = 1'b1; ra[3] = 16'd2;
    drain(3);

    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = ($urandom_range(0, 9) == 0) ? 16'hF000 + 16'($urandom_range(0, 255))
                                               : 16'($urandom_range(0, 63));
        end
      end
      ld_we   = ($urandom_range(0, 6) == 0);
      ld_addr = ($urandom_range(0, 4) == 0) ? (16'h1000 | 16'($urandom_range(0, 63)))
                                            : 16'($urandom_range(0, 63));
      ld_data = 16'($urandom);
      tick();
    end
    drain(10);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, want 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
